lcd_rgb565_capture: RTL
=======================

Name: lcd_rgb565_capture

Overview:
Receive-side counterpart of the RGB565 LCD controller. Monitors the parallel LCD timing (active-low HSync/VSync plus 16-bit RGB565 pixel bus) on the same pixel clock. It recovers the active-window position and writes each active pixel back into a 480x272 frame RAM with a linear address. Used as a loopback/frame-grab block and as the self-checking capture end in LCD subsystem benches.

Parameters:
H_ACT, 480, active pixels per line
V_ACT, 272, active lines per frame
H_BP, 2, pixel clocks from HSync deassertion (rising edge) to first active pixel
V_BP, 2, HSync pulses from VSync deassertion to first active line
ADDR_W, 17, frame RAM address width (must hold H_ACT*V_ACT-1 = 130559)

Ports:
iClk  in  1  pixel clock; all inputs synchronous to it
iRsn  in  1  asynchronous active-low reset
iLcdHSync  in  1  line sync, active low
iLcdVSync  in  1  frame sync, active low
iLcdR  in  5  red
iLcdG  in  6  green
iLcdB  in  5  blue
oRamWrEn  out  1  frame RAM write strobe, one cycle per pixel
oRamWrAddr  out  ADDR_W  write address = line*H_ACT + col
oRamWrData  out  16  {R,G,B} packed RGB565
oFrameDone  out  1  one-cycle pulse after the last pixel of a complete frame is written
oErrLine  out  1  one-cycle pulse: line shorter than H_ACT
oErrFrame  out  1  one-cycle pulse: VSync asserted before V_ACT lines captured
oFrameCnt  out  8  count of complete frames, wraps 255->0

Behaviour:
- Reset, async on iRsn low: all outputs 0, state IDLE, all counters 0, input registers loaded with HSync=1, VSync=1, pixel=0.
- Input stage: HSync, VSync and pixel bus are registered once. Edges are detected on the registered copies against the previous value.
- Latency: a pixel present on the input bus at cycle N produces oRamWrEn=1 with that data at cycle N+2 (1 input register + 1 output register).
- States:
  - IDLE: wait for VSync falling edge -> VSYNC.
  - VSYNC: wait for VSync rising edge -> VBP, with line counter cleared.
  - VBP: count HSync falling edges. After V_BP of them -> HWAIT.
  - HWAIT: wait for HSync rising edge -> HBP, with column counter cleared.
  - HBP: count H_BP cycles -> ACTIVE.
  - ACTIVE: each cycle write the registered pixel at the current address, then increment column and address. After H_ACT writes -> LINEEND.
  - LINEEND: increment line. If line == V_ACT: pulse oFrameDone, increment oFrameCnt, clear address, go to IDLE. Otherwise -> HWAIT.
- Address counter: incremental, never a multiplier. Its value never exceeds H_ACT*V_ACT-1 and it returns to 0 on frame completion or error.
- HSync falling edge while in ACTIVE with column < H_ACT:
  - pulse oErrLine
  - stop writing immediately
  - advance address to the start of the next line (line+1)*H_ACT
  - continue as if LINEEND occurred
- VSync falling edge in any state other than IDLE/VSYNC:
  - pulse oErrFrame
  - no oFrameDone, oFrameCnt unchanged
  - clear line, column and address
  - go to VSYNC (restart capture)
- If an HSync falling edge and a VSync falling edge occur in the same cycle, the frame error takes priority. oErrLine is not pulsed in that cycle.
- oRamWrEn is never asserted outside ACTIVE. oRamWrAddr/oRamWrData hold their last values when oRamWrEn=0.
- Reset mid-frame aborts capture with no error pulses. The first frame after reset is captured only from the next VSync falling edge.

Decomposition:
- Shared package lcd_pkg: H_ACT, V_ACT, porch constants (shared with the LCD controller), FSM state encoding, and the RGB565 pack/unpack helper functions.
- One natural sub-module, lcd_sync_edge: registers HSync/VSync and emits rise/fall strobes. The FSM, counters and write port stay in the top module.

Test Plan:
1. Drive one legal frame with pixel value = address[15:0] -> 130560 writes. Addresses run 0..130559 strictly in order with data == address[15:0]. Exactly one oFrameDone, on the cycle after the write to 130559, and oFrameCnt=1.
2. Apply a single pixel 16'hF800 at line 0 col 0 -> a write to addr 0 with data 16'hF800 appears exactly 2 cycles after the pixel is on the bus.
3. Truncate line 5 to 300 pixels by asserting HSync early -> one oErrLine pulse. Line 6 col 0 is written at addr 2880, and the frame still completes with oFrameDone.
4. Assert VSync during line 100 -> one oErrFrame pulse, oFrameCnt unchanged, no oFrameDone. The following legal frame writes starting at addr 0 and completes normally.
5. Assert iRsn low mid-line (line 50, col 200), then release -> all outputs 0 while reset is low. No writes occur until after the next VSync falling edge, and no error pulses are produced.
6. Run 256 back-to-back legal frames -> oFrameCnt wraps to 0, and oErrLine/oErrFrame are never asserted.

Source files
------------

// File: rtl/lcd_pkg.sv
// lcd_pkg: LCD panel geometry, porch timing, capture FSM states and RGB565 helpers.
package lcd_pkg;
  localparam int LCD_H_ACT = 480;
  localparam int LCD_V_ACT = 272;
  localparam int LCD_H_BP = 2;
  localparam int LCD_V_BP = 2;
  localparam int LCD_ADDR_W = 17;
  typedef enum logic [2:0] {
    IDLE,
    VSYNC,
    VBP,
    HWAIT,
    HBP,
    ACTIVE,
    LINEEND
  } capState_e;
  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;
  function automatic logic [15:0] packRgb565(input logic [4:0] r, input logic [5:0] g, input logic [4:0] b);
    return {r, g, b};
  endfunction
  function automatic rgb565_t unpackRgb565(input logic [15:0] pix);
    return rgb565_t'(pix);
  endfunction
endpackage

// File: rtl/lcd_rgb565_capture_if.sv
// lcd_rgb565_capture_if: parallel LCD timing/pixel bus in, frame RAM write port out.
interface lcd_rgb565_capture_if #(
  parameter int ADDR_W = lcd_pkg::LCD_ADDR_W
);
  logic iLcdHSync;
  logic iLcdVSync;
  logic [4:0] iLcdR;
  logic [5:0] iLcdG;
  logic [4:0] iLcdB;
  logic oRamWrEn;
  logic [ADDR_W-1:0] oRamWrAddr;
  logic [15:0] oRamWrData;
  logic oFrameDone;
  logic oErrLine;
  logic oErrFrame;
  logic [7:0] oFrameCnt;
  modport master (
    output iLcdHSync, iLcdVSync, iLcdR, iLcdG, iLcdB,
    input oRamWrEn, oRamWrAddr, oRamWrData, oFrameDone, oErrLine, oErrFrame, oFrameCnt
  );
  modport slave (
    input iLcdHSync, iLcdVSync, iLcdR, iLcdG, iLcdB,
    output oRamWrEn, oRamWrAddr, oRamWrData, oFrameDone, oErrLine, oErrFrame, oFrameCnt
  );
endinterface

// File: rtl/lcd_sync_edge.sv
// lcd_sync_edge: registers HSync/VSync once and flags rising/falling edges of the registered copies.
module lcd_sync_edge (
  input  logic iClk,
  input  logic iRsn,
  input  logic iHSync,
  input  logic iVSync,
  output logic oHSyncRise,
  output logic oHSyncFall,
  output logic oVSyncRise,
  output logic oVSyncFall
);
  logic hSync, vSync, hSyncQ, vSyncQ;
  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      hSync <= 1'b1;
      vSync <= 1'b1;
      hSyncQ <= 1'b1;
      vSyncQ <= 1'b1;
    end else begin
      hSync <= iHSync;
      vSync <= iVSync;
      hSyncQ <= hSync;
      vSyncQ <= vSync;
    end
  end
  assign oHSyncRise = hSync & ~hSyncQ;
  assign oHSyncFall = hSyncQ & ~hSync;
  assign oVSyncRise = vSync & ~vSyncQ;
  assign oVSyncFall = vSyncQ & ~vSync;
endmodule

// File: rtl/lcd_rgb565_capture.sv
// lcd_rgb565_capture: recovers the LCD active window and writes every active pixel to a linear frame RAM address.
module lcd_rgb565_capture
  import lcd_pkg::*;
#(
  parameter int H_ACT = LCD_H_ACT,
  parameter int V_ACT = LCD_V_ACT,
  parameter int H_BP = LCD_H_BP,
  parameter int V_BP = LCD_V_BP,
  parameter int ADDR_W = LCD_ADDR_W
) (
  input logic iClk,
  input logic iRsn,
  lcd_rgb565_capture_if.slave lcd
);
  localparam int COL_W = $clog2(H_ACT + 1);
  localparam int LINE_W = $clog2(V_ACT + 1);
  localparam int PORCH_W = $clog2((H_BP > V_BP ? H_BP : V_BP) + 1);
  capState_e state, stateNxt;
  logic hsRise, hsFall, vsRise, vsFall;
  logic [COL_W-1:0] col, colNxt;
  logic [LINE_W-1:0] line, lineNxt;
  logic [PORCH_W-1:0] porchCnt, porchNxt;
  logic [ADDR_W-1:0] addr, addrNxt, lineBase, baseNxt;
  logic [7:0] frameCnt, frameCntNxt;
  logic [15:0] pixQ;
  logic wrEn, frameDone, errLine, errFrame;
  logic wrEnQ, frameDoneQ, errLineQ, errFrameQ;
  logic [ADDR_W-1:0] wrAddrQ;
  logic [15:0] wrDataQ;
  lcd_sync_edge uSyncEdge (
    .iClk(iClk),
    .iRsn(iRsn),
    .iHSync(lcd.iLcdHSync),
    .iVSync(lcd.iLcdVSync),
    .oHSyncRise(hsRise),
    .oHSyncFall(hsFall),
    .oVSyncRise(vsRise),
    .oVSyncFall(vsFall)
  );
  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      state <= IDLE;
      col <= '0;
      line <= '0;
      porchCnt <= '0;
      addr <= '0;
      lineBase <= '0;
      frameCnt <= '0;
      pixQ <= '0;
      wrEnQ <= 1'b0;
      wrAddrQ <= '0;
      wrDataQ <= '0;
      frameDoneQ <= 1'b0;
      errLineQ <= 1'b0;
      errFrameQ <= 1'b0;
    end else begin
      state <= stateNxt;
      col <= colNxt;
      line <= lineNxt;
      porchCnt <= porchNxt;
      addr <= addrNxt;
      lineBase <= baseNxt;
      frameCnt <= frameCntNxt;
      pixQ <= packRgb565(lcd.iLcdR, lcd.iLcdG, lcd.iLcdB);
      wrEnQ <= wrEn;
      if (wrEn) begin
        wrAddrQ <= addr;
        wrDataQ <= pixQ;
      end
      frameDoneQ <= frameDone;
      errLineQ <= errLine;
      errFrameQ <= errFrame;
    end
  end
  // A VSync fall mid-capture restarts the frame and outranks any line error in the same cycle.
  always_comb begin
    stateNxt = state;
    colNxt = col;
    lineNxt = line;
    porchNxt = porchCnt;
    addrNxt = addr;
    baseNxt = lineBase;
    frameCntNxt = frameCnt;
    wrEn = 1'b0;
    frameDone = 1'b0;
    errLine = 1'b0;
    errFrame = 1'b0;
    if (vsFall && state != IDLE && state != VSYNC) begin
      errFrame = 1'b1;
      stateNxt = VSYNC;
      colNxt = '0;
      lineNxt = '0;
      addrNxt = '0;
      baseNxt = '0;
    end else begin
      case (state)
        IDLE: stateNxt = vsFall ? VSYNC : IDLE;
        VSYNC: begin
          if (vsRise) begin
            stateNxt = VBP;
            lineNxt = '0;
            porchNxt = '0;
          end
        end
        VBP: begin
          if (hsFall) begin
            porchNxt = porchCnt + 1'b1;
            stateNxt = (porchCnt == PORCH_W'(V_BP - 1)) ? HWAIT : VBP;
          end
        end
        // The cycle that detects the HSync rise is the first porch cycle.
        HWAIT: begin
          if (hsRise) begin
            colNxt = '0;
            porchNxt = PORCH_W'(1);
            stateNxt = (H_BP <= 1) ? ACTIVE : HBP;
          end
        end
        HBP: begin
          porchNxt = porchCnt + 1'b1;
          stateNxt = (porchCnt == PORCH_W'(H_BP - 1)) ? ACTIVE : HBP;
        end
        ACTIVE: begin
          if (hsFall) begin
            errLine = 1'b1;
            stateNxt = LINEEND;
          end else begin
            wrEn = 1'b1;
            colNxt = col + 1'b1;
            stateNxt = (col == COL_W'(H_ACT - 1)) ? LINEEND : ACTIVE;
            addrNxt = (col == COL_W'(H_ACT - 1)) ? addr : addr + 1'b1;
          end
        end
        LINEEND: begin
          if (line == LINE_W'(V_ACT - 1)) begin
            frameDone = 1'b1;
            frameCntNxt = frameCnt + 8'd1;
            lineNxt = '0;
            addrNxt = '0;
            baseNxt = '0;
            stateNxt = IDLE;
          end else begin
            lineNxt = line + 1'b1;
            baseNxt = lineBase + ADDR_W'(H_ACT);
            addrNxt = lineBase + ADDR_W'(H_ACT);
            stateNxt = HWAIT;
          end
        end
        default: stateNxt = IDLE;
      endcase
    end
  end
  assign lcd.oRamWrEn = wrEnQ;
  assign lcd.oRamWrAddr = wrAddrQ;
  assign lcd.oRamWrData = wrDataQ;
  assign lcd.oFrameDone = frameDoneQ;
  assign lcd.oErrLine = errLineQ;
  assign lcd.oErrFrame = errFrameQ;
  assign lcd.oFrameCnt = frameCnt;
endmodule
